// File: rtl/wall_drawer.sv
// Wall pixel streamer: on each accepted start, erases the previously drawn
// wall column (if any), then draws the new one with a hole cut out, one
// pixel per cycle. All outputs are registered from next-state values, so the
// first pixel of a pass is presented in the cycle right after acceptance.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// ERASE | scanning prev_x column block with background colour
// DRAW  | scanning cur_x column block, wall colour except inside the hole
// DONE  | single-cycle done pulse, then back to IDLE
module wall_drawer #(
  parameter int         WALL_WIDTH  = 4,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         HOLE_H      = 50,
  parameter logic [2:0] WALL_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wall_x,
  input  logic [6:0] hole_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] col, col_nx;
  logic [6:0] row, row_nx;
  logic [7:0] cur_x, cur_x_nx;
  logic [6:0] cur_hole, cur_hole_nx;
  logic [7:0] prev_x, prev_x_nx;
  logic       prev_valid, prev_valid_nx;

  logic [7:0] x_nx;
  logic [6:0] y_nx;
  logic [2:0] colour_nx;
  logic       plot_nx, busy_nx, done_nx;

  logic       col_last, last_pix;
  logic [7:0] base;
  logic [8:0] x_sum;
  logic [7:0] hole_end;
  logic       in_hole;

  assign col_last = (col == 8'(WALL_WIDTH - 1));
  assign last_pix = col_last && (row == 7'(SCREEN_H - 1));

  // Next-state, scan counters and pass bookkeeping
  always_comb begin
    state_nx      = state;
    col_nx        = col;
    row_nx        = row;
    cur_x_nx      = cur_x;
    cur_hole_nx   = cur_hole;
    prev_x_nx     = prev_x;
    prev_valid_nx = prev_valid;
    case (state)
      IDLE: begin
        if (start) begin
          cur_x_nx    = wall_x;
          cur_hole_nx = hole_y;
          col_nx      = '0;
          row_nx      = '0;
          state_nx    = prev_valid ? ERASE : DRAW;
        end
      end
      ERASE, DRAW: begin
        if (last_pix) begin
          col_nx = '0;
          row_nx = '0;
          if (state == ERASE) begin
            state_nx = DRAW;
          end else begin
            prev_x_nx     = cur_x;
            prev_valid_nx = 1'b1;
            state_nx      = DONE;
          end
        end else if (col_last) begin
          col_nx = '0;
          row_nx = row + 7'd1;
        end else begin
          col_nx = col + 8'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pixel presented next cycle, derived from the upcoming scan position.
  // The hole bound is formed at 8 bits so a low hole simply runs off-screen.
  always_comb begin
    base      = (state_nx == ERASE) ? prev_x : cur_x_nx;
    x_sum     = {1'b0, base} + {1'b0, col_nx};
    hole_end  = {1'b0, cur_hole_nx} + 8'(HOLE_H);
    in_hole   = ({1'b0, row_nx} >= {1'b0, cur_hole_nx}) && ({1'b0, row_nx} < hole_end);
    x_nx      = '0;
    y_nx      = '0;
    colour_nx = BG_COLOUR;
    plot_nx   = 1'b0;
    busy_nx   = 1'b0;
    done_nx   = 1'b0;
    case (state_nx)
      ERASE, DRAW: begin
        x_nx      = x_sum[7:0];
        y_nx      = row_nx;
        plot_nx   = (x_sum < 9'(SCREEN_W));
        busy_nx   = 1'b1;
        colour_nx = ((state_nx == DRAW) && !in_hole) ? WALL_COLOUR : BG_COLOUR;
      end
      DONE: done_nx = 1'b1;
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      cur_x      <= '0;
      cur_hole   <= '0;
      prev_x     <= '0;
      prev_valid <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour     <= BG_COLOUR;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      col        <= col_nx;
      row        <= row_nx;
      cur_x      <= cur_x_nx;
      cur_hole   <= cur_hole_nx;
      prev_x     <= prev_x_nx;
      prev_valid <= prev_valid_nx;
      x_out      <= x_nx;
      y_out      <= y_nx;
      colour     <= colour_nx;
      plot       <= plot_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_wall_drawer.sv
// Scoreboard bench for wall_drawer: stimulus pushes expected pixels and
// pass timing records; a negedge monitor pops and compares them.
module tb_wall_drawer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] wall_x = '0;
  logic [6:0] hole_y = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, busy, done;

  wall_drawer dut (
    .clk(clk), .reset(reset), .start(start), .wall_x(wall_x), .hole_y(hole_y),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;
  typedef struct { int st; int len; int dn; } pass_t;

  pix_t  pix_q[$];
  pass_t pass_q[$];
  int    tests = 0;
  int    fails = 0;

  logic [7:0] m_prev_x = '0;
  bit         m_prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of one pass: accepted at edge n, first busy cycle counted as n.
  task automatic push_pass(input logic [7:0] wx, input logic [6:0] hy, input int n);
    pass_t p;
    pix_t  q;
    int    xs;
    if (m_prev_valid) begin
      for (int r = 0; r < 120; r++)
        for (int c = 0; c < 4; c++) begin
          xs = int'(m_prev_x) + c;
          if (xs < 160) begin
            q.x = xs[7:0]; q.y = r[6:0]; q.c = 3'b000;
            pix_q.push_back(q);
          end
        end
    end
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 4; c++) begin
        xs = int'(wx) + c;
        if (xs < 160) begin
          q.x = xs[7:0]; q.y = r[6:0];
          q.c = (r >= int'(hy) && r < int'(hy) + 50) ? 3'b000 : 3'b010;
          pix_q.push_back(q);
        end
      end
    p.st  = n;
    p.len = m_prev_valid ? 960 : 480;
    p.dn  = n + p.len;
    pass_q.push_back(p);
    m_prev_x     = wx;
    m_prev_valid = 1'b1;
  endtask

  // Called at negedge+#1; from_done means the DUT is currently in DONE.
  task automatic launch(input logic [7:0] wx, input logic [6:0] hy, input bit from_done,
                        input bit hold, output int n);
    n = from_done ? cyc + 2 : cyc + 1;
    push_pass(wx, hy, n);
    wall_x = wx;
    hole_y = hy;
    start  = 1'b1;
    if (!hold) begin
      repeat (from_done ? 2 : 1) @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic wait_done(output int d);
    int k;
    k = 0;
    @(negedge clk); #1;
    while (!done && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done pulse", k);
    end
    d = cyc;
  endtask

  task automatic wait_cyc(input int target);
    int k;
    k = 0;
    while (cyc != target && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    if (cyc != target) begin
      tests++; fails++;
      $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, target);
    end
  endtask

  // Monitor: pops pixels on plot, checks pass start, length and done timing
  bit busy_prev = 1'b0;
  int busy_cnt  = 0;
  always @(negedge clk) begin
    if (reset) begin
      busy_prev = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (plot) begin
        if (!busy) check("plot_without_busy", 32'(busy), 32'd1);
        if (pix_q.size() == 0) begin
          check("unexpected_pixel", 32'({x_out, y_out}), 32'hFFFF_FFFF);
        end else begin
          pix_t e;
          e = pix_q.pop_front();
          check("pixel_xyc", 32'({x_out, y_out, colour}), 32'({e.x, e.y, e.c}));
        end
      end
      if (busy && !busy_prev) begin
        if (pass_q.size() == 0) check("unexpected_pass_start", 32'(cyc), 32'hFFFF_FFFF);
        else check("pass_start_cycle", 32'(cyc), 32'(pass_q[0].st));
      end
      if (busy) busy_cnt++;
      if (done) begin
        check("done_busy_low", 32'(busy), 32'd0);
        if (pass_q.size() == 0) begin
          check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          pass_t p;
          p = pass_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(p.dn));
          check("busy_length", 32'(busy_cnt), 32'(p.len));
          check("pixels_left_at_done", 32'(pix_q.size()), 32'd0);
        end
        busy_cnt = 0;
      end
      busy_prev = busy;
    end
  end

  initial begin
    int n, d;
    repeat (3) @(negedge clk);
    #1;
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;

    // Off-screen first pass: no erase, nothing plotted
    launch(8'd160, 7'd30, 1'b0, 1'b0, n);
    wait_done(d);
    // Erase of off-screen wall, draw at 100 with hole 30..79
    launch(8'd100, 7'd30, 1'b1, 1'b0, n);
    wait_done(d);
    // Erase 100..103, hole truncated at bottom
    launch(8'd96, 7'd90, 1'b1, 1'b0, n);
    wait_done(d);
    // Right edge clipping
    launch(8'd158, 7'd0, 1'b1, 1'b0, n);
    wait_done(d);
    // start held high: back-to-back passes with one idle cycle
    launch(8'd20, 7'd10, 1'b1, 1'b1, n);
    wait_done(d);
    launch(8'd40, 7'd60, 1'b1, 1'b0, n);
    wall_x = 8'd7;
    hole_y = 7'd0;
    // stray start during DRAW must not queue a pass
    wait_cyc(n + 700);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(d);
    repeat (30) @(negedge clk);
    #1;

    // Reset in the middle of DRAW row 60
    launch(8'd50, 7'd20, 1'b0, 1'b0, n);
    wait_cyc(n + 720);
    #1 reset = 1'b1;
    #1;
    check("midreset_plot", 32'(plot), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    pix_q.delete();
    pass_q.delete();
    m_prev_valid = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    @(negedge clk); #1;
    launch(8'd80, 7'd40, 1'b0, 1'b0, n);
    wait_done(d);
    check("post_reset_done", 32'(d), 32'(n + 480));
    repeat (5) @(negedge clk);
    check("pix_q_empty_end", 32'(pix_q.size()), 32'd0);
    check("pass_q_empty_end", 32'(pass_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
